// File: rtl/calculator.sv
// rtl/calculator.sv - RPN 8-bit calculator with parenthesis depth tracking
//
// calculator: executes one opcode per clock.
//   clk     in  1  rising-edge clock
//   rst     in  1  synchronous active-high reset
//   opcode  in  3  000 add, 001 mul, 010 '(', 011 ')', 100 push, 101 '=', 11x nop
//   operand in  8  push data, ignored otherwise
//   result  out 8  value captured by the last '='
//   ready   out 1  result holds a fresh evaluation
//
// calc_stack_alu: operand stack plus add/mul datapath.
//   push/add/mul/clear  in  1  one-hot-ish commands from the decoder
//   operand             in  8  push data
//   top                 out 8  current top-of-stack entry
//   sp_count            out    entry count, 0..DEPTH

module calc_stack_alu #(
    parameter int DEPTH = 16,
    parameter int SPW   = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic           add,
    input  logic           mul,
    input  logic           clear,
    input  logic [7:0]     operand,
    output logic [7:0]     top,
    output logic [SPW-1:0] sp_count
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]     stack [0:DEPTH-1];
    logic [SPW-1:0] stack_pointer;

    logic [IW-1:0]  w_idx_top;
    logic [IW-1:0]  w_idx_below;
    logic [IW-1:0]  w_idx_push;
    logic [7:0]     w_a;
    logic [7:0]     w_b;
    logic [7:0]     w_sum;
    logic [7:0]     w_prod;

    // Indices wrap when sp is too small; every use is guarded by an sp check.
    assign w_idx_top   = IW'(stack_pointer - SPW'(1));
    assign w_idx_below = IW'(stack_pointer - SPW'(2));
    assign w_idx_push  = IW'(stack_pointer);
    assign w_a         = stack[w_idx_below];
    assign w_b         = stack[w_idx_top];
    // Low 8 bits are identical for signed and unsigned operands.
    assign w_sum       = w_a + w_b;
    assign w_prod      = w_a * w_b;

    assign top      = w_b;
    assign sp_count = stack_pointer;

    always_ff @(posedge clk) begin
        if (rst) begin
            stack_pointer <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= 8'h00;
            end
        end else if (clear) begin
            stack_pointer <= '0;
        end else if (push) begin
            if (stack_pointer < SPW'(DEPTH)) begin
                stack[w_idx_push] <= operand;
                stack_pointer     <= stack_pointer + SPW'(1);
            end
        end else if ((add || mul) && (stack_pointer >= SPW'(2))) begin
            stack[w_idx_below] <= add ? w_sum : w_prod;
            stack_pointer      <= stack_pointer - SPW'(1);
        end
    end
endmodule

module calculator #(
    parameter int DEPTH     = 16,
    parameter int PAREN_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic [7:0] operand,
    output logic [7:0] result,
    output logic       ready
);
    localparam int SPW = $clog2(DEPTH) + 1;
    localparam int PDW = (PAREN_MAX > 0) ? $clog2(PAREN_MAX + 1) : 1;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_MUL   = 3'b001;
    localparam logic [2:0] OP_OPEN  = 3'b010;
    localparam logic [2:0] OP_CLOSE = 3'b011;
    localparam logic [2:0] OP_PUSH  = 3'b100;
    localparam logic [2:0] OP_EQUAL = 3'b101;

    logic [7:0]     r_result;
    logic           r_ready;
    logic [PDW-1:0] r_paren_depth;

    logic [7:0]     w_top;
    logic [SPW-1:0] w_sp;
    logic           w_push;
    logic           w_add;
    logic           w_mul;
    logic           w_clear;

    assign w_push  = (opcode == OP_PUSH);
    assign w_add   = (opcode == OP_ADD);
    assign w_mul   = (opcode == OP_MUL);
    // '=' on an empty stack must not disturb anything but ready.
    assign w_clear = (opcode == OP_EQUAL) && (w_sp != '0);

    calc_stack_alu #(
        .DEPTH (DEPTH),
        .SPW   (SPW)
    ) stack_alu (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .add      (w_add),
        .mul      (w_mul),
        .clear    (w_clear),
        .operand  (operand),
        .top      (w_top),
        .sp_count (w_sp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result      <= 8'h00;
            r_ready       <= 1'b0;
            r_paren_depth <= '0;
        end else begin
            case (opcode)
                OP_ADD, OP_MUL, OP_PUSH: begin
                    r_ready <= 1'b0;
                end
                OP_OPEN: begin
                    r_ready <= 1'b0;
                    if (r_paren_depth < PDW'(PAREN_MAX)) begin
                        r_paren_depth <= r_paren_depth + PDW'(1);
                    end
                end
                OP_CLOSE: begin
                    r_ready <= 1'b0;
                    if (r_paren_depth != '0) begin
                        r_paren_depth <= r_paren_depth - PDW'(1);
                    end
                end
                OP_EQUAL: begin
                    if (w_sp != '0) begin
                        r_result      <= w_top;
                        r_ready       <= 1'b1;
                        r_paren_depth <= '0;
                    end else begin
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;
    assign ready  = r_ready;
endmodule

// File: tb/tb_calculator.sv
// tb/tb_calculator.sv - directed self-checking bench for calculator
module tb_calculator;
    localparam logic [2:0] ADD   = 3'b000;
    localparam logic [2:0] MUL   = 3'b001;
    localparam logic [2:0] OPEN  = 3'b010;
    localparam logic [2:0] CLOSE = 3'b011;
    localparam logic [2:0] PUSH  = 3'b100;
    localparam logic [2:0] EQUAL = 3'b101;
    localparam logic [2:0] NOP   = 3'b110;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic [7:0] operand;
    logic [7:0] result;
    logic       ready;

    int n_cmp = 0;
    int n_err = 0;

    calculator #(
        .DEPTH     (16),
        .PAREN_MAX (15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .operand (operand),
        .result  (result),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [2:0] op, input logic [7:0] val);
        @(negedge clk);
        opcode  = op;
        operand = val;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        opcode = NOP;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step(ADD, 8'h00);
        step(ADD, 8'h00);
        step(ADD, 8'h00);
        n_cmp++;
        if (dut.stack_alu.stack_pointer !== 5'd0) begin
            n_err++;
            $display("FAIL reset_sp got %0d exp 0", dut.stack_alu.stack_pointer);
        end
        n_cmp++;
        if (result !== 8'h00) begin
            n_err++;
            $display("FAIL reset_result got %h exp 00", result);
        end
        n_cmp++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready got %b exp 0", ready);
        end
    endtask

    task automatic test_expression();
        step(OPEN, 8'h00);
        step(PUSH, 8'd2);
        step(PUSH, 8'd3);
        step(MUL, 8'h00);
        n_cmp++;
        if (dut.stack_alu.stack_pointer !== 5'd1 || dut.stack_alu.stack[0] !== 8'h06) begin
            n_err++;
            $display("FAIL expr_mul got sp=%0d s0=%h exp sp=1 s0=06",
                     dut.stack_alu.stack_pointer, dut.stack_alu.stack[0]);
        end
        step(OPEN, 8'h00);
        step(PUSH, 8'd10);
        step(PUSH, 8'd4);
        step(ADD, 8'h00);
        step(PUSH, 8'd3);
        step(ADD, 8'h00);
        step(CLOSE, 8'h00);
        step(PUSH, 8'hEC);
        step(MUL, 8'h00);
        n_cmp++;
        if (dut.stack_alu.stack_pointer !== 5'd2 || dut.stack_alu.stack[0] !== 8'h06 ||
            dut.stack_alu.stack[1] !== 8'hAC) begin
            n_err++;
            $display("FAIL expr_neg_mul got sp=%0d s0=%h s1=%h exp sp=2 s0=06 s1=AC",
                     dut.stack_alu.stack_pointer, dut.stack_alu.stack[0], dut.stack_alu.stack[1]);
        end
        step(ADD, 8'h00);
        step(OPEN, 8'h00);
        step(PUSH, 8'd6);
        step(PUSH, 8'd5);
        step(ADD, 8'h00);
        step(CLOSE, 8'h00);
        step(ADD, 8'h00);
        n_cmp++;
        if (dut.stack_alu.stack_pointer !== 5'd1 || dut.stack_alu.stack[0] !== 8'hBD) begin
            n_err++;
            $display("FAIL expr_pre_eq got sp=%0d s0=%h exp sp=1 s0=BD",
                     dut.stack_alu.stack_pointer, dut.stack_alu.stack[0]);
        end
        n_cmp++;
        if (dut.r_paren_depth !== 4'd1) begin
            n_err++;
            $display("FAIL expr_paren got %0d exp 1", dut.r_paren_depth);
        end
        step(EQUAL, 8'h00);
        n_cmp++;
        if (result !== 8'hBD || ready !== 1'b1 || dut.stack_alu.stack_pointer !== 5'd0 ||
            dut.r_paren_depth !== 4'd0) begin
            n_err++;
            $display("FAIL expr_eq got res=%h rdy=%b sp=%0d pd=%0d exp res=BD rdy=1 sp=0 pd=0",
                     result, ready, dut.stack_alu.stack_pointer, dut.r_paren_depth);
        end
    endtask

    task automatic test_wrap();
        step(PUSH, 8'd200);
        step(PUSH, 8'd100);
        step(ADD, 8'h00);
        n_cmp++;
        if (dut.stack_alu.stack[0] !== 8'h2C || ready !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_add got s0=%h rdy=%b exp s0=2C rdy=0",
                     dut.stack_alu.stack[0], ready);
        end
        step(PUSH, 8'd16);
        step(PUSH, 8'd16);
        step(MUL, 8'h00);
        n_cmp++;
        if (dut.stack_alu.stack_pointer !== 5'd2 || dut.stack_alu.stack[1] !== 8'h00) begin
            n_err++;
            $display("FAIL wrap_mul got sp=%0d s1=%h exp sp=2 s1=00",
                     dut.stack_alu.stack_pointer, dut.stack_alu.stack[1]);
        end
        do_reset();
    endtask

    task automatic test_full();
        for (int i = 1; i <= 17; i++) begin
            step(PUSH, 8'(i));
        end
        n_cmp++;
        if (dut.stack_alu.stack_pointer !== 5'd16 || dut.stack_alu.stack[15] !== 8'd16 ||
            dut.stack_alu.stack[0] !== 8'd1) begin
            n_err++;
            $display("FAIL full_push got sp=%0d s15=%h s0=%h exp sp=16 s15=10 s0=01",
                     dut.stack_alu.stack_pointer, dut.stack_alu.stack[15], dut.stack_alu.stack[0]);
        end
        for (int i = 0; i < 15; i++) begin
            step(ADD, 8'h00);
        end
        n_cmp++;
        if (dut.stack_alu.stack_pointer !== 5'd1 || dut.stack_alu.stack[0] !== 8'h88) begin
            n_err++;
            $display("FAIL full_adds got sp=%0d s0=%h exp sp=1 s0=88",
                     dut.stack_alu.stack_pointer, dut.stack_alu.stack[0]);
        end
    endtask

    task automatic test_noops();
        step(CLOSE, 8'h00);
        step(ADD, 8'h00);
        n_cmp++;
        if (dut.stack_alu.stack_pointer !== 5'd1 || dut.stack_alu.stack[0] !== 8'h88 ||
            dut.r_paren_depth !== 4'd0) begin
            n_err++;
            $display("FAIL noop_close_add got sp=%0d s0=%h pd=%0d exp sp=1 s0=88 pd=0",
                     dut.stack_alu.stack_pointer, dut.stack_alu.stack[0], dut.r_paren_depth);
        end
        step(EQUAL, 8'h00);
        n_cmp++;
        if (result !== 8'h88 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL noop_eq got res=%h rdy=%b exp res=88 rdy=1", result, ready);
        end
        step(NOP, 8'h00);
        step(3'b111, 8'h00);
        n_cmp++;
        if (result !== 8'h88 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL nop_hold got res=%h rdy=%b exp res=88 rdy=1", result, ready);
        end
        step(PUSH, 8'd7);
        n_cmp++;
        if (ready !== 1'b0 || result !== 8'h88) begin
            n_err++;
            $display("FAIL push_clears got rdy=%b res=%h exp rdy=0 res=88", ready, result);
        end
        step(EQUAL, 8'h00);
        step(EQUAL, 8'h00);
        n_cmp++;
        if (ready !== 1'b0 || result !== 8'h07) begin
            n_err++;
            $display("FAIL eq_empty got rdy=%b res=%h exp rdy=0 res=07", ready, result);
        end
    endtask

    task automatic test_paren();
        for (int i = 0; i < 16; i++) begin
            step(OPEN, 8'h00);
        end
        n_cmp++;
        if (dut.r_paren_depth !== 4'd15) begin
            n_err++;
            $display("FAIL paren_sat got %0d exp 15", dut.r_paren_depth);
        end
        for (int i = 0; i < 16; i++) begin
            step(CLOSE, 8'h00);
        end
        n_cmp++;
        if (dut.r_paren_depth !== 4'd0 || dut.stack_alu.stack_pointer !== 5'd0) begin
            n_err++;
            $display("FAIL paren_floor got pd=%0d sp=%0d exp pd=0 sp=0",
                     dut.r_paren_depth, dut.stack_alu.stack_pointer);
        end
    endtask

    task automatic test_reset_mid();
        step(PUSH, 8'd9);
        step(EQUAL, 8'h00);
        step(PUSH, 8'd5);
        n_cmp++;
        if (dut.stack_alu.stack_pointer !== 5'd1 || dut.stack_alu.stack[0] !== 8'd5 ||
            result !== 8'h09) begin
            n_err++;
            $display("FAIL mid_setup got sp=%0d s0=%h res=%h exp sp=1 s0=05 res=09",
                     dut.stack_alu.stack_pointer, dut.stack_alu.stack[0], result);
        end
        @(negedge clk);
        rst     = 1'b1;
        opcode  = PUSH;
        operand = 8'd9;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++;
        if (dut.stack_alu.stack_pointer !== 5'd0 || result !== 8'h00 || ready !== 1'b0 ||
            dut.stack_alu.stack[0] !== 8'h00) begin
            n_err++;
            $display("FAIL mid_reset got sp=%0d res=%h rdy=%b s0=%h exp sp=0 res=00 rdy=0 s0=00",
                     dut.stack_alu.stack_pointer, result, ready, dut.stack_alu.stack[0]);
        end
    endtask

    initial begin
        rst     = 1'b1;
        opcode  = NOP;
        operand = 8'h00;
        test_reset();
        test_expression();
        test_wrap();
        test_full();
        test_noops();
        test_paren();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
